// File: rtl/uart_receiver.sv
// 8N1 UART receiver, LSB first, FREQUENCY clock cycles per bit.
// Optional macro UART_RX_MAJORITY_EN: 2-of-3 majority voting on start/data/stop decisions.
module uart_receiver #(
  parameter int FREQUENCY = 8
) (
  input  logic       clk,
  input  logic       i_Rst_n,
  input  logic       i_Serial_Data,
  output logic       o_DV,
  output logic [7:0] o_Byte,
  output logic       o_Sig_Active,
  output logic       o_Framing_Err,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    CLEANUP = 3'd4
  } state_t;

  localparam logic [7:0] LAST_CNT = 8'(FREQUENCY - 1);
  localparam logic [7:0] MID_CNT  = 8'((FREQUENCY - 1) / 2);

  state_t     state;
  logic [7:0] cnt;
  logic [2:0] idx;
  logic [7:0] shift_byte;
  logic       sync1;
  logic       sync2;
  logic       armed;
  logic       line;

  always_ff @(posedge clk) begin
    if (!i_Rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= i_Serial_Data;
      sync2 <= sync1;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  // Two previous synchronized samples; FREQUENCY must be at least 6 so the
  // three-sample window stays inside one bit period.
  logic hist1;
  logic hist2;

  always_ff @(posedge clk) begin
    if (!i_Rst_n) begin
      hist1 <= 1'b1;
      hist2 <= 1'b1;
    end else begin
      hist1 <= sync2;
      hist2 <= hist1;
    end
  end

  assign line = (sync2 & hist1) | (sync2 & hist2) | (hist1 & hist2);
`else
  assign line = sync2;
`endif

  assign dbg_state = state;

  // armed blocks restart after a framing error until the line has been seen high,
  // so a held-low line (break) yields a single error and then waits.
  always_ff @(posedge clk) begin
    if (!i_Rst_n) begin
      state         <= IDLE;
      cnt           <= 8'd0;
      idx           <= 3'd0;
      shift_byte    <= 8'd0;
      armed         <= 1'b1;
      o_Byte        <= 8'd0;
      o_DV          <= 1'b0;
      o_Framing_Err <= 1'b0;
      o_Sig_Active  <= 1'b0;
    end else begin
      o_DV          <= 1'b0;
      o_Framing_Err <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= 8'd0;
          idx <= 3'd0;
          if (sync2) armed <= 1'b1;
          if (armed && !sync2) begin
            state        <= START;
            o_Sig_Active <= 1'b1;
          end
        end
        START: begin
          if (cnt == MID_CNT) begin
            cnt <= 8'd0;
            if (!line) begin
              state <= DATA;
            end else begin
              state        <= IDLE;
              o_Sig_Active <= 1'b0;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DATA: begin
          if (cnt == LAST_CNT) begin
            cnt             <= 8'd0;
            shift_byte[idx] <= line;
            if (idx == 3'd7) begin
              idx   <= 3'd0;
              state <= STOP;
            end else begin
              idx <= idx + 3'd1;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        STOP: begin
          if (cnt == LAST_CNT) begin
            cnt          <= 8'd0;
            state        <= CLEANUP;
            o_Sig_Active <= 1'b0;
            if (line) begin
              o_Byte <= shift_byte;
              o_DV   <= 1'b1;
            end else begin
              o_Framing_Err <= 1'b1;
              armed         <= 1'b0;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        CLEANUP: begin
          state <= IDLE;
        end
        default: begin
          state        <= IDLE;
          cnt          <= 8'd0;
          idx          <= 3'd0;
          o_Sig_Active <= 1'b0;
        end
      endcase
    end
  end

endmodule
